// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection phase scheduler.
// The phase encoding doubles as the debug view exposed on phase_o.
package traffic_pkg;

  typedef enum logic [2:0] {
    R1_G = 3'd0,
    R1_Y = 3'd1,
    AR1  = 3'd2,
    R2_G = 3'd3,
    R2_Y = 3'd4,
    AR2  = 3'd5,
    WALK = 3'd6
  } phase_e;

  // Lamp bundle in the order Road1 GYR, Road2 GYR, Walk GR.
  typedef struct packed {
    logic r1_g;
    logic r1_y;
    logic r1_r;
    logic r2_g;
    logic r2_y;
    logic r2_r;
    logic walk_g;
    logic walk_r;
  } lamps_t;

  function automatic int tmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Everything red unless the phase lights exactly one road or the walk lamp.
  function automatic lamps_t lamp_decode(input phase_e ph);
    lamps_t l;
    l        = '0;
    l.r1_r   = 1'b1;
    l.r2_r   = 1'b1;
    l.walk_r = 1'b1;
    case (ph)
      R1_G:    begin l.r1_g   = 1'b1; l.r1_r   = 1'b0; end
      R1_Y:    begin l.r1_y   = 1'b1; l.r1_r   = 1'b0; end
      R2_G:    begin l.r2_g   = 1'b1; l.r2_r   = 1'b0; end
      R2_Y:    begin l.r2_y   = 1'b1; l.r2_r   = 1'b0; end
      WALK:    begin l.walk_g = 1'b1; l.walk_r = 1'b0; end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter for phase durations. A load writes (duration - 1); the count
// then falls to zero and holds there, so done is high on the last cycle.
module phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          i_load,
  input  logic [TW-1:0] i_value,
  output logic          o_done,
  output logic [TW-1:0] o_value
);

  logic [TW-1:0] r_cnt;

  // Load has priority; otherwise count down and saturate at zero.
  always_ff @(posedge clk) begin
    if (i_load)
      r_cnt <= i_value;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - TW'(1);
  end

  assign o_done  = (r_cnt == '0);
  assign o_value = r_cnt;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase scheduler with a latched pedestrian request.
// Road1 rests in green until Road2 traffic or a pedestrian is pending.
// Optional macro WALK_FLASH_EN: the last T_FLASH cycles of WALK flash Walk_G.
module traffic_phase_ctrl #(
  parameter int T_G1    = 10,
  parameter int T_G2    = 8,
  parameter int T_Y     = 3,
  parameter int T_AR    = 1,
  parameter int T_WALK  = 6,
  parameter int T_FLASH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       walk_req,
  input  logic       car2_sense,
  output logic       Road1_G,
  output logic       Road1_Y,
  output logic       Road1_R,
  output logic       Road2_G,
  output logic       Road2_Y,
  output logic       Road2_R,
  output logic       Walk_G,
  output logic       Walk_R,
  output logic [2:0] phase_o,
  output logic       walk_pend_o
);
  import traffic_pkg::*;

  localparam int TMAX = tmax(tmax(tmax(T_G1, T_G2), tmax(T_Y, T_AR)), tmax(T_WALK, T_FLASH));
  localparam int TW   = $clog2(TMAX + 1);

  phase_e        r_state;
  phase_e        w_state_next;
  logic          r_car2_pend;
  logic          r_walk_pend;
  logic          w_done;
  logic          w_load;
  logic [TW-1:0] w_tval;
  logic [TW-1:0] w_dur;
  logic [TW-1:0] w_load_value;
  lamps_t        w_lamps;

  // Every timer expiry either moves to a new phase or re-arms R1_G, so the
  // timer reloads on each expiry with the duration of the phase coming next.
  assign w_load       = rst | w_done;
  assign w_load_value = rst ? TW'(T_AR - 1) : w_dur;

  phase_timer #(.TW(TW)) u_timer (
    .clk     (clk),
    .i_load  (w_load),
    .i_value (w_load_value),
    .o_done  (w_done),
    .o_value (w_tval)
  );

  // State register: reset parks in the all-red clearance before Road1.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= AR2;
    else
      r_state <= w_state_next;
  end

  // Next-state: advance only on timer expiry; R1_G re-arms while idle.
  always_comb begin
    w_state_next = r_state;
    if (w_done) begin
      case (r_state)
        R1_G:    w_state_next = (r_car2_pend || r_walk_pend) ? R1_Y : R1_G;
        R1_Y:    w_state_next = AR1;
        AR1:     w_state_next = R2_G;
        R2_G:    w_state_next = R2_Y;
        R2_Y:    w_state_next = AR2;
        AR2:     w_state_next = r_walk_pend ? WALK : R1_G;
        WALK:    w_state_next = R1_G;
        default: w_state_next = AR2;
      endcase
    end
  end

  // Duration (minus one) of the phase about to be entered.
  always_comb begin
    case (w_state_next)
      R1_G:    w_dur = TW'(T_G1 - 1);
      R1_Y:    w_dur = TW'(T_Y - 1);
      R2_G:    w_dur = TW'(T_G2 - 1);
      R2_Y:    w_dur = TW'(T_Y - 1);
      WALK:    w_dur = TW'(T_WALK - 1);
      default: w_dur = TW'(T_AR - 1);
    endcase
  end

  // Request latches: clear on entry to the serving phase beats a same-cycle
  // request, and requests arriving while being served are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_car2_pend <= 1'b0;
      r_walk_pend <= 1'b0;
    end else begin
      if (w_state_next == R2_G && r_state != R2_G)
        r_car2_pend <= 1'b0;
      else if (car2_sense && r_state != R2_G)
        r_car2_pend <= 1'b1;

      if (w_state_next == WALK && r_state != WALK)
        r_walk_pend <= 1'b0;
      else if (walk_req && r_state != WALK)
        r_walk_pend <= 1'b1;
    end
  end

  // Output decode: Moore lamps straight from the state register.
`ifdef WALK_FLASH_EN
  logic [TW-1:0] w_flash_idx;
  assign w_flash_idx = TW'(T_FLASH - 1) - w_tval;
`endif

  always_comb begin
    w_lamps = lamp_decode(r_state);
`ifdef WALK_FLASH_EN
    // Flash window counts 0,1,2.. from its first cycle; lamp is dark on even.
    if (r_state == WALK && w_tval < TW'(T_FLASH))
      w_lamps.walk_g = w_flash_idx[0];
`endif
  end

  assign Road1_G     = w_lamps.r1_g;
  assign Road1_Y     = w_lamps.r1_y;
  assign Road1_R     = w_lamps.r1_r;
  assign Road2_G     = w_lamps.r2_g;
  assign Road2_Y     = w_lamps.r2_y;
  assign Road2_R     = w_lamps.r2_r;
  assign Walk_G      = w_lamps.walk_g;
  assign Walk_R      = w_lamps.walk_r;
  assign phase_o     = r_state;
  assign walk_pend_o = r_walk_pend;

  // Safety: at most one road non-red; walk only with both roads red.
  a_one_road: assert property (@(posedge clk) disable iff (rst) (Road1_R || Road2_R));
  a_walk_red: assert property (@(posedge clk) disable iff (rst) Walk_G |-> (Road1_R && Road2_R));
  a_timer_rng: assert property (@(posedge clk) disable iff (rst) (w_tval <= TW'(TMAX - 1)));

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: every cycle of each scripted phase
// is compared against hand-derived phase, lamp and walk-pending values.
module tb_traffic_phase_ctrl;

  localparam logic [2:0] P_R1_G = 3'd0;
  localparam logic [2:0] P_R1_Y = 3'd1;
  localparam logic [2:0] P_AR1  = 3'd2;
  localparam logic [2:0] P_R2_G = 3'd3;
  localparam logic [2:0] P_R2_Y = 3'd4;
  localparam logic [2:0] P_AR2  = 3'd5;
  localparam logic [2:0] P_WALK = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       walk_req = 1'b0;
  logic       car2_sense = 1'b0;
  logic       Road1_G, Road1_Y, Road1_R;
  logic       Road2_G, Road2_Y, Road2_R;
  logic       Walk_G, Walk_R;
  logic [2:0] phase_o;
  logic       walk_pend_o;
  logic [7:0] lamps_obs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .walk_req    (walk_req),
    .car2_sense  (car2_sense),
    .Road1_G     (Road1_G),
    .Road1_Y     (Road1_Y),
    .Road1_R     (Road1_R),
    .Road2_G     (Road2_G),
    .Road2_Y     (Road2_Y),
    .Road2_R     (Road2_R),
    .Walk_G      (Walk_G),
    .Walk_R      (Walk_R),
    .phase_o     (phase_o),
    .walk_pend_o (walk_pend_o)
  );

  assign lamps_obs = {Road1_G, Road1_Y, Road1_R, Road2_G, Road2_Y, Road2_R, Walk_G, Walk_R};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected lamps {R1 GYR, R2 GYR, Walk GR}; k is the cycle index within WALK.
  function automatic logic [7:0] exp_lamps(input logic [2:0] ph, input int k);
    logic flash_on;
    logic wg;
`ifdef WALK_FLASH_EN
    flash_on = 1'b1;
`else
    flash_on = 1'b0;
`endif
    wg = (flash_on && k >= 3) ? ((k % 2) == 0) : 1'b1;
    case (ph)
      P_R1_G:  return 8'b100_001_01;
      P_R1_Y:  return 8'b010_001_01;
      P_R2_G:  return 8'b001_100_01;
      P_R2_Y:  return 8'b001_010_01;
      P_WALK:  return {6'b001_001, wg, 1'b0};
      default: return 8'b001_001_01;
    endcase
  endfunction

  // Checks n consecutive cycles of one phase, stepping to the next negedge.
  task automatic run_phase(input string tag, input logic [2:0] ph, input int n, input logic wp);
    for (int i = 0; i < n; i++) begin
      check({tag, "_phase"}, 32'(phase_o), 32'(ph));
      check({tag, "_lamps"}, 32'(lamps_obs), 32'(exp_lamps(ph, i)));
      check({tag, "_wpend"}, 32'(walk_pend_o), 32'(wp));
      @(negedge clk);
    end
  endtask

  initial begin
    // Clock/reset: two reset edges, then release.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_phase("rst", P_AR2, 1, 1'b0);

    // Idle: Road1 green re-arms with nothing waiting.
    run_phase("idle", P_R1_G, 20, 1'b0);

    // Road2 car pulse at R1_G cycle 4, then full road cycle.
    run_phase("car_a", P_R1_G, 3, 1'b0);
    car2_sense = 1'b1;
    run_phase("car_b", P_R1_G, 1, 1'b0);
    car2_sense = 1'b0;
    run_phase("car_c", P_R1_G, 6, 1'b0);
    run_phase("car_r1y", P_R1_Y, 3, 1'b0);
    run_phase("car_ar1", P_AR1, 1, 1'b0);

    // Walk pulse during Road2 green, served after AR2.
    run_phase("wlk_a", P_R2_G, 2, 1'b0);
    walk_req = 1'b1;
    run_phase("wlk_b", P_R2_G, 1, 1'b0);
    walk_req = 1'b0;
    run_phase("wlk_c", P_R2_G, 5, 1'b1);
    run_phase("wlk_r2y", P_R2_Y, 3, 1'b1);
    run_phase("wlk_ar2", P_AR2, 1, 1'b1);
    run_phase("wlk_walk", P_WALK, 6, 1'b0);

    // Walk request held through a whole round including WALK.
    walk_req = 1'b1;
    run_phase("hld_a", P_R1_G, 1, 1'b0);
    run_phase("hld_b", P_R1_G, 9, 1'b1);
    run_phase("hld_r1y", P_R1_Y, 3, 1'b1);
    run_phase("hld_ar1", P_AR1, 1, 1'b1);
    run_phase("hld_r2g", P_R2_G, 8, 1'b1);
    run_phase("hld_r2y", P_R2_Y, 3, 1'b1);
    run_phase("hld_ar2", P_AR2, 1, 1'b1);
    run_phase("hld_walk", P_WALK, 6, 1'b0);
    run_phase("rel_a", P_R1_G, 1, 1'b0);
    walk_req = 1'b0;
    run_phase("rel_b", P_R1_G, 9, 1'b1);
    run_phase("rel_r1y", P_R1_Y, 3, 1'b1);
    run_phase("rel_ar1", P_AR1, 1, 1'b1);
    run_phase("rel_r2g", P_R2_G, 8, 1'b1);
    run_phase("rel_r2y", P_R2_Y, 3, 1'b1);
    run_phase("rel_ar2", P_AR2, 1, 1'b1);
    run_phase("rel_walk", P_WALK, 6, 1'b0);

    // Reset in R1_G with both requests pending: both must be dropped.
    car2_sense = 1'b1;
    walk_req   = 1'b1;
    run_phase("r1rst_a", P_R1_G, 1, 1'b0);
    car2_sense = 1'b0;
    walk_req   = 1'b0;
    run_phase("r1rst_b", P_R1_G, 3, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_phase("r1rst_ar2", P_AR2, 1, 1'b0);
    run_phase("r1rst_idle", P_R1_G, 20, 1'b0);

    // Reset mid Road2 green with walk pending.
    car2_sense = 1'b1;
    run_phase("r2rst_a", P_R1_G, 1, 1'b0);
    car2_sense = 1'b0;
    run_phase("r2rst_b", P_R1_G, 9, 1'b0);
    run_phase("r2rst_r1y", P_R1_Y, 3, 1'b0);
    run_phase("r2rst_ar1", P_AR1, 1, 1'b0);
    run_phase("r2rst_c", P_R2_G, 2, 1'b0);
    walk_req   = 1'b1;
    car2_sense = 1'b1;
    run_phase("r2rst_d", P_R2_G, 1, 1'b0);
    walk_req   = 1'b0;
    car2_sense = 1'b0;
    run_phase("r2rst_e", P_R2_G, 1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_phase("r2rst_ar2", P_AR2, 1, 1'b0);
    run_phase("r2rst_idle", P_R1_G, 20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
